// File: rtl/uart_pkg.sv
// Shared UART types and constants.
package uart_pkg;

  localparam int unsigned UART_RX_FIFO_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic       parity_err;
    logic       frame_err;
    logic [7:0] word;
  } rx_fifo_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Generic WIDTH x DEPTH register array: synchronous write, combinational read.
module uart_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT FIFO with sticky overflow and almost-full feedback for RTS.
// Define UART_RX_FIFO_ERR_TAG_EN to store and present per-word frame/parity error tags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = UART_RX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned DEPTH_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_rx_done,
  input  logic [7:0]         i_rx_word,
  input  logic               i_rx_frame_error,
  input  logic               i_rx_parity_error,
  input  logic               i_flush,
  input  logic               i_rd_req,
  input  logic [DEPTH_W:0]   i_almfull_level,
  input  logic               i_overflow_clr,
  output logic [7:0]         o_rd_data,
  output logic               o_rd_frame_error,
  output logic               o_rd_parity_error,
  output logic [DEPTH_W:0]   o_level,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_almfull,
  output logic               o_overflow
);

  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W+1)'(DEPTH);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int unsigned ENTRY_W = $bits(rx_fifo_entry_t);
`else
  localparam int unsigned ENTRY_W = 8;
`endif

  logic [DEPTH_W:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [ENTRY_W-1:0] mem_wdata, mem_rdata;
  rx_fifo_entry_t     head;
  logic               empty, full, pop_ok, push_ok, ovf_set, mem_we;
  logic [DEPTH_W:0]   level, almfull_thr;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                   (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);
  assign pop_ok  = i_rd_req && !empty;
  assign push_ok = i_rx_done && (!full || pop_ok);
  assign ovf_set = i_rx_done && full && !pop_ok && !i_flush;
  assign mem_we  = push_ok && !i_flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // set wins over a same-cycle clear
    if (i_overflow_clr) overflow_d = 1'b0;
    if (ovf_set)        overflow_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign mem_wdata = rx_fifo_entry_t'{parity_err: i_rx_parity_error,
                                      frame_err:  i_rx_frame_error,
                                      word:       i_rx_word};
  assign head      = rx_fifo_entry_t'(mem_rdata);
`else
  logic unused_err;
  assign unused_err = i_rx_frame_error ^ i_rx_parity_error;
  assign mem_wdata  = i_rx_word;
  assign head       = rx_fifo_entry_t'{parity_err: 1'b0, frame_err: 1'b0, word: mem_rdata};
`endif

  uart_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (DEPTH_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q[DEPTH_W-1:0]),
    .i_wdata (mem_wdata),
    .i_raddr (rd_ptr_q[DEPTH_W-1:0]),
    .o_rdata (mem_rdata)
  );

  // zero and out-of-range thresholds both collapse to DEPTH
  always_comb begin
    almfull_thr = i_almfull_level;
    if (i_almfull_level == '0 || i_almfull_level > DEPTH_L) almfull_thr = DEPTH_L;
  end

  assign o_level           = level;
  assign o_empty           = empty;
  assign o_full            = full;
  assign o_almfull         = (level >= almfull_thr);
  assign o_overflow        = overflow_q;
  assign o_rd_data         = empty ? '0 : head.word;
  assign o_rd_frame_error  = empty ? 1'b0 : head.frame_err;
  assign o_rd_parity_error = empty ? 1'b0 : head.parity_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo; tag expectations follow UART_RX_FIFO_ERR_TAG_EN.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       i_clk = 1'b0;
  logic       i_nrst = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_word = '0;
  logic       i_rx_frame_error = 1'b0;
  logic       i_rx_parity_error = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_rd_req = 1'b0;
  logic [4:0] i_almfull_level = 5'd12;
  logic       i_overflow_clr = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_frame_error, o_rd_parity_error;
  logic [4:0] o_level;
  logic       o_empty, o_full, o_almfull, o_overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [9:0] sb_q[$];
  logic       exp_ovf = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk             (i_clk),
    .i_nrst            (i_nrst),
    .i_rx_done         (i_rx_done),
    .i_rx_word         (i_rx_word),
    .i_rx_frame_error  (i_rx_frame_error),
    .i_rx_parity_error (i_rx_parity_error),
    .i_flush           (i_flush),
    .i_rd_req          (i_rd_req),
    .i_almfull_level   (i_almfull_level),
    .i_overflow_clr    (i_overflow_clr),
    .o_rd_data         (o_rd_data),
    .o_rd_frame_error  (o_rd_frame_error),
    .o_rd_parity_error (o_rd_parity_error),
    .o_level           (o_level),
    .o_empty           (o_empty),
    .o_full            (o_full),
    .o_almfull         (o_almfull),
    .o_overflow        (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    int unsigned sz;
    int unsigned thr;
    logic [9:0]  head;
    sz   = sb_q.size();
    thr  = (i_almfull_level == 0 || i_almfull_level > DEPTH) ? DEPTH : int'(i_almfull_level);
    head = (sz == 0) ? 10'h000 : sb_q[0];
    check("level",   32'(o_level),   32'(sz));
    check("empty",   32'(o_empty),   32'(sz == 0));
    check("full",    32'(o_full),    32'(sz == DEPTH));
    check("almfull", 32'(o_almfull), 32'(sz >= thr));
    check("ovf",     32'(o_overflow), 32'(exp_ovf));
    check("rd_data", 32'(o_rd_data), 32'(head[7:0]));
`ifdef UART_RX_FIFO_ERR_TAG_EN
    check("frame_tag",  32'(o_rd_frame_error),  32'(head[8]));
    check("parity_tag", 32'(o_rd_parity_error), 32'(head[9]));
`else
    check("frame_tag",  32'(o_rd_frame_error),  32'd0);
    check("parity_tag", 32'(o_rd_parity_error), 32'd0);
`endif
  endtask

  // One clock with the given inputs; caller is at posedge+1.
  task automatic cycle(input logic done, input logic [7:0] w, input logic fe, input logic pe,
                       input logic rd, input logic fl, input logic clr);
    logic full_m, pop_m, push_m, set_m;
    full_m = (sb_q.size() == DEPTH);
    pop_m  = rd && (sb_q.size() != 0);
    push_m = done && (!full_m || pop_m);
    set_m  = done && full_m && !pop_m && !fl;
    i_rx_done = done; i_rx_word = w; i_rx_frame_error = fe; i_rx_parity_error = pe;
    i_rd_req = rd; i_flush = fl; i_overflow_clr = clr;
    @(posedge i_clk); #1;
    i_rx_done = 1'b0; i_rd_req = 1'b0; i_flush = 1'b0; i_overflow_clr = 1'b0;
    if (fl) sb_q.delete();
    else begin
      if (pop_m)  void'(sb_q.pop_front());
      if (push_m) sb_q.push_back({pe, fe, w});
    end
    if (clr)   exp_ovf = 1'b0;
    if (set_m) exp_ovf = 1'b1;
    check_outputs();
  endtask

  task automatic push(input logic [7:0] w);
    cycle(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    check_outputs();
    @(negedge i_clk); i_nrst = 1'b1;
    @(posedge i_clk); #1;
    check_outputs();

    push(8'hA5);
    push(8'h3C);
    pop();
    pop();

    i_almfull_level = 5'd12;
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hFF);
    for (int i = 0; i < 16; i++) pop();

    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("head_after_pp", 32'(o_rd_data), 32'h41);
    for (int i = 0; i < 16; i++) pop();

    for (int i = 0; i < 3; i++) pop();
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pop();

    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    for (int i = 0; i < 11; i++) pop();
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    i_almfull_level = 5'd0;
    for (int i = 0; i < 16; i++) push(8'(i));
    i_almfull_level = 5'd20;
    check_outputs();
    i_almfull_level = 5'd1;
    for (int i = 0; i < 16; i++) pop();
    push(8'hC3);
    pop();

    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pop();
    pop();

    i_almfull_level = 5'd6;
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 10) == 0));

    for (int i = 0; i < 4; i++) push(8'(8'hE0 + i));
    #3 i_nrst = 1'b0;
    #1;
    sb_q.delete();
    exp_ovf = 1'b0;
    check_outputs();
    @(negedge i_clk); i_nrst = 1'b1;
    @(posedge i_clk); #1;
    check_outputs();
    push(8'h9A);
    pop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
